mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one SRAM port between instruction fetch and the data stage.
// Data requests and fetches alternate when both are pending, and a branch flush suppresses the fetch response.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DATA_ACC = 2'd1,
    S_INST_ACC = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant_data;
  logic              w_grant_inst;
  logic              w_data_pend;
  logic              w_inst_pend;
  logic              r_last_data;
  logic              r_kill;
  logic              r_sram_req;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [DATA_W-1:0] r_if_instr;
  logic [DATA_W-1:0] r_mem_rdata;

  assign w_data_pend = mem_rd | mem_wr;
  assign w_inst_pend = if_req & ~flush;

  always_comb begin
    w_next_state = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On contention, the side that did not win last time gets the port.
        if (w_data_pend && (!w_inst_pend || !r_last_data)) begin
          w_grant_data = 1'b1;
          w_next_state = S_DATA_ACC;
        end else if (w_inst_pend) begin
          w_grant_inst = 1'b1;
          w_next_state = S_INST_ACC;
        end
      end
      S_DATA_ACC, S_INST_ACC: begin
        if (sram_ready) w_next_state = S_DONE;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_data  <= 1'b0;
      r_kill       <= 1'b0;
      r_sram_req   <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_if_instr   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_sram_req <= (w_next_state == S_DATA_ACC) || (w_next_state == S_INST_ACC);
      if (w_grant_data) begin
        r_last_data  <= 1'b1;
        r_sram_addr  <= mem_addr;
        r_sram_wdata <= mem_wdata;
        r_sram_we    <= mem_wr;
      end else if (w_grant_inst) begin
        r_last_data <= 1'b0;
        r_sram_addr <= if_addr;
        r_sram_we   <= 1'b0;
      end
      if (r_state == S_DATA_ACC && sram_ready) r_mem_rdata <= sram_rdata;
      if (r_state == S_INST_ACC && sram_ready) r_if_instr  <= sram_rdata;
      // A flush seen at any point of the fetch, up to the ready cycle, kills its response.
      if (r_state == S_INST_ACC && flush)      r_kill <= 1'b1;
      else if (r_state == S_DONE)              r_kill <= 1'b0;
    end
  end

  // last_data still identifies the access that is completing while in DONE.
  assign mem_ready  = (r_state == S_DONE) &&  r_last_data;
  assign if_valid   = (r_state == S_DONE) && !r_last_data && !r_kill;
  assign if_stall   = if_req & ~if_valid;
  assign mem_stall  = w_data_pend & ~mem_ready;
  assign if_instr   = r_if_instr;
  assign mem_rdata  = r_mem_rdata;
  assign sram_req   = r_sram_req;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule
